// File: rtl/stopwatch_ctrl_fsm_if.sv
// Stopwatch control bundle: front-panel buttons and UART byte in, counter/display controls out.
interface stopwatch_ctrl_fsm_if #(
    parameter int MD_W  = 1,
    parameter int LAP_W = 4
);
    logic             btn_run_stop;
    logic             btn_clear;
    logic             btn_mode;
    logic             btn_lap;
    logic [7:0]       rx_data;
    logic             rx_done;
    logic             enable;
    logic             clear;
    logic             rd_en;
    logic [MD_W-1:0]  run_md;
    logic             lap_hold;
    logic [LAP_W-1:0] lap_cnt;
    logic [1:0]       state_o;

    modport master (
        output btn_run_stop, btn_clear, btn_mode, btn_lap, rx_data, rx_done,
        input  enable, clear, rd_en, run_md, lap_hold, lap_cnt, state_o
    );

    modport slave (
        input  btn_run_stop, btn_clear, btn_mode, btn_lap, rx_data, rx_done,
        output enable, clear, rd_en, run_md, lap_hold, lap_cnt, state_o
    );
endinterface

// File: rtl/stopwatch_ctrl_fsm.sv
// Stopwatch run/stop/lap/clear sequencer driven by buttons or UART command bytes.
//
// state | meaning
// STOP  | counter halted, display live
// RUN   | counter running, display live
// LAP   | counter running, display frozen
// CLEAR | counter cleared for CLEAR_CYCLES cycles
module stopwatch_ctrl_fsm #(
    parameter int         NUM_MODES    = 2,
    parameter int         MD_W         = 1,
    parameter int         CLEAR_CYCLES = 1,
    parameter int         LAP_W        = 4,
    parameter logic [7:0] CMD_RUN      = "r",
    parameter logic [7:0] CMD_STOP     = "s",
    parameter logic [7:0] CMD_CLEAR    = "c",
    parameter logic [7:0] CMD_MODE     = "m",
    parameter logic [7:0] CMD_LAP      = "l"
) (
    input logic                  clk,
    input logic                  reset,
    stopwatch_ctrl_fsm_if.slave  bus
);
    localparam logic [1:0] ST_STOP  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_LAP   = 2'd2;
    localparam logic [1:0] ST_CLEAR = 2'd3;

    localparam logic [LAP_W-1:0] LAP_MAX  = {LAP_W{1'b1}};
    localparam logic [MD_W-1:0]  MD_LAST  = MD_W'(NUM_MODES - 1);
    localparam logic [7:0]       CLR_LOAD = 8'(CLEAR_CYCLES - 1);

    logic [1:0]       state_q, state_d;
    logic [7:0]       cmd_q;
    logic             rd_en_q;
    logic [MD_W-1:0]  run_md_q, run_md_d, md_next;
    logic [LAP_W-1:0] lap_cnt_q, lap_cnt_d;
    logic [7:0]       clr_cnt_q, clr_cnt_d;

    logic ev_rs, ev_clr, ev_md, ev_lap;
    logic act_rs, act_clr, act_md, act_lap;

    // 'r' and 's' both toggle run/stop, matching the single run/stop button
    assign ev_rs  = bus.btn_run_stop | (cmd_q == CMD_RUN) | (cmd_q == CMD_STOP);
    assign ev_clr = bus.btn_clear    | (cmd_q == CMD_CLEAR);
    assign ev_md  = bus.btn_mode     | (cmd_q == CMD_MODE);
    assign ev_lap = bus.btn_lap      | (cmd_q == CMD_LAP);

    assign act_rs  = ev_rs;
    assign act_clr = ev_clr & ~ev_rs;
    assign act_md  = ev_md  & ~ev_rs & ~ev_clr;
    assign act_lap = ev_lap & ~ev_rs & ~ev_clr & ~ev_md;

    assign md_next = (run_md_q == MD_LAST) ? '0 : run_md_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        run_md_d  = run_md_q;
        lap_cnt_d = lap_cnt_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            ST_STOP: begin
                if (act_rs) begin
                    state_d = ST_RUN;
                end else if (act_clr) begin
                    state_d   = ST_CLEAR;
                    run_md_d  = '0;
                    lap_cnt_d = '0;
                    clr_cnt_d = CLR_LOAD;
                end
            end
            ST_RUN: begin
                if (act_rs) begin
                    state_d = ST_STOP;
                end else if (act_lap) begin
                    state_d = ST_LAP;
                    if (lap_cnt_q != LAP_MAX) lap_cnt_d = lap_cnt_q + 1'b1;
                end else if (act_md) begin
                    run_md_d = md_next;
                end
            end
            ST_LAP: begin
                if (act_rs) begin
                    state_d = ST_STOP;
                end else if (act_lap) begin
                    state_d = ST_RUN;
                end else if (act_md) begin
                    run_md_d = md_next;
                end
            end
            ST_CLEAR: begin
                if (clr_cnt_q == 8'd0) state_d = ST_STOP;
                else                   clr_cnt_d = clr_cnt_q - 8'd1;
            end
            default: state_d = ST_STOP;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= ST_STOP;
            cmd_q     <= 8'h00;
            rd_en_q   <= 1'b0;
            run_md_q  <= '0;
            lap_cnt_q <= '0;
            clr_cnt_q <= 8'd0;
        end else begin
            state_q   <= state_d;
            cmd_q     <= bus.rx_done ? bus.rx_data : 8'h00;
            rd_en_q   <= bus.rx_done;
            run_md_q  <= run_md_d;
            lap_cnt_q <= lap_cnt_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    assign bus.enable   = (state_q == ST_RUN) || (state_q == ST_LAP);
    assign bus.clear    = (state_q == ST_CLEAR);
    assign bus.lap_hold = (state_q == ST_LAP);
    assign bus.rd_en    = rd_en_q;
    assign bus.run_md   = run_md_q;
    assign bus.lap_cnt  = lap_cnt_q;
    assign bus.state_o  = state_q;
endmodule

// File: tb/tb_stopwatch_ctrl_fsm.sv
// Directed bench for stopwatch_ctrl_fsm with NUM_MODES=3, LAP_W=2, CLEAR_CYCLES=4.
module tb_stopwatch_ctrl_fsm;
    localparam int NUM_MODES    = 3;
    localparam int MD_W         = 2;
    localparam int CLEAR_CYCLES = 4;
    localparam int LAP_W        = 2;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    stopwatch_ctrl_fsm_if #(.MD_W(MD_W), .LAP_W(LAP_W)) bus ();

    stopwatch_ctrl_fsm #(
        .NUM_MODES(NUM_MODES), .MD_W(MD_W),
        .CLEAR_CYCLES(CLEAR_CYCLES), .LAP_W(LAP_W)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_run();
        bus.btn_run_stop = 1'b1; tick(); bus.btn_run_stop = 1'b0;
    endtask
    task automatic pulse_mode();
        bus.btn_mode = 1'b1; tick(); bus.btn_mode = 1'b0;
    endtask
    task automatic pulse_lap();
        bus.btn_lap = 1'b1; tick(); bus.btn_lap = 1'b0;
    endtask
    task automatic send_byte(input logic [7:0] b);
        bus.rx_data = b; bus.rx_done = 1'b1; tick(); bus.rx_done = 1'b0; bus.rx_data = 8'h00;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, ".state"},    32'(bus.state_o),  32'd0);
        check({tag, ".enable"},   32'(bus.enable),   32'd0);
        check({tag, ".clear"},    32'(bus.clear),    32'd0);
        check({tag, ".rd_en"},    32'(bus.rd_en),    32'd0);
        check({tag, ".lap_hold"}, 32'(bus.lap_hold), 32'd0);
        check({tag, ".run_md"},   32'(bus.run_md),   32'd0);
        check({tag, ".lap_cnt"},  32'(bus.lap_cnt),  32'd0);
    endtask

    initial begin
        bus.btn_run_stop = 1'b0; bus.btn_clear = 1'b0; bus.btn_mode = 1'b0;
        bus.btn_lap = 1'b0; bus.rx_data = 8'h00; bus.rx_done = 1'b0;

        // reset
        tick(); tick();
        check_reset_vals("reset");
        reset = 1'b1;
        tick();

        // button run/stop
        pulse_run();
        check("btn_run.state",  32'(bus.state_o), 32'd1);
        check("btn_run.enable", 32'(bus.enable),  32'd1);
        pulse_run();
        check("btn_stop.state",  32'(bus.state_o), 32'd0);
        check("btn_stop.enable", 32'(bus.enable),  32'd0);

        // UART 'r': rd_en at N+1, enable at N+2
        send_byte("r");
        check("uart_r.rd_en_n1",  32'(bus.rd_en),  32'd1);
        check("uart_r.enable_n1", 32'(bus.enable), 32'd0);
        tick();
        check("uart_r.rd_en_n2",  32'(bus.rd_en),  32'd0);
        check("uart_r.enable_n2", 32'(bus.enable), 32'd1);
        send_byte("s"); tick();
        check("uart_s.state", 32'(bus.state_o), 32'd0);

        // unrecognised byte
        send_byte(8'h41);
        check("uart_41.rd_en", 32'(bus.rd_en),   32'd1);
        tick();
        check("uart_41.rd_en_off", 32'(bus.rd_en),   32'd0);
        check("uart_41.state",     32'(bus.state_o), 32'd0);
        tick();
        check("uart_41.state_late", 32'(bus.state_o), 32'd0);

        // mode in STOP ignored
        pulse_mode();
        check("stop_mode.run_md", 32'(bus.run_md), 32'd0);

        // mode wrap in RUN: 1,2,0,1
        pulse_run();
        pulse_mode(); check("mode1", 32'(bus.run_md), 32'd1);
        pulse_mode(); check("mode2", 32'(bus.run_md), 32'd2);
        pulse_mode(); check("mode3", 32'(bus.run_md), 32'd0);
        pulse_mode(); check("mode4", 32'(bus.run_md), 32'd1);
        check("mode.state", 32'(bus.state_o), 32'd1);
        pulse_run();
        check("mode_stop.run_md", 32'(bus.run_md), 32'd1);
        pulse_run();
        check("mode_restart.state",  32'(bus.state_o), 32'd1);
        check("mode_restart.run_md", 32'(bus.run_md),  32'd1);

        // lap saturation: 5 entries, lap_cnt 1,2,3,3,3
        for (int i = 1; i <= 5; i++) begin
            pulse_lap();
            check($sformatf("lap%0d.state", i),    32'(bus.state_o),  32'd2);
            check($sformatf("lap%0d.hold", i),     32'(bus.lap_hold), 32'd1);
            check($sformatf("lap%0d.cnt", i),      32'(bus.lap_cnt),  (i > 3) ? 32'd3 : 32'(i));
            check($sformatf("lap%0d.enable", i),   32'(bus.enable),   32'd1);
            if (i < 5) begin
                pulse_lap();
                check($sformatf("unlap%0d.hold", i), 32'(bus.lap_hold), 32'd0);
                check($sformatf("unlap%0d.cnt", i),  32'(bus.lap_cnt),  (i > 3) ? 32'd3 : 32'(i));
            end
        end
        pulse_mode();
        check("lap_mode.state",  32'(bus.state_o), 32'd2);
        check("lap_mode.run_md", 32'(bus.run_md),  32'd2);
        pulse_run();
        check("lap_stop.hold",   32'(bus.lap_hold), 32'd0);
        check("lap_stop.enable", 32'(bus.enable),   32'd0);
        check("lap_stop.state",  32'(bus.state_o),  32'd0);

        // clear for exactly 4 cycles; 'r' during CLEAR ignored
        bus.btn_clear = 1'b1; tick(); bus.btn_clear = 1'b0;
        check("clr1.clear",   32'(bus.clear),   32'd1);
        check("clr1.state",   32'(bus.state_o), 32'd3);
        check("clr1.run_md",  32'(bus.run_md),  32'd0);
        check("clr1.lap_cnt", 32'(bus.lap_cnt), 32'd0);
        send_byte("r");
        check("clr2.clear", 32'(bus.clear), 32'd1);
        check("clr2.rd_en", 32'(bus.rd_en), 32'd1);
        tick(); check("clr3.clear", 32'(bus.clear), 32'd1);
        tick(); check("clr4.clear", 32'(bus.clear), 32'd1);
        tick();
        check("clr_done.clear",  32'(bus.clear),   32'd0);
        check("clr_done.state",  32'(bus.state_o), 32'd0);
        check("clr_done.enable", 32'(bus.enable),  32'd0);
        tick();
        check("clr_after.state", 32'(bus.state_o), 32'd0);

        // priority: btn_run_stop beats UART 'c' in the same cycle
        send_byte("c");
        pulse_run();
        check("prio.state", 32'(bus.state_o), 32'd1);
        check("prio.clear", 32'(bus.clear),   32'd0);

        // reset during LAP with a command byte pending
        pulse_lap();
        check("prerst.state", 32'(bus.state_o), 32'd2);
        send_byte("r");
        reset = 1'b0; tick();
        check_reset_vals("rst_lap");
        reset = 1'b1; tick();
        check("rst_lap.dropped", 32'(bus.state_o), 32'd0);

        // reset during CLEAR
        bus.btn_clear = 1'b1; tick(); bus.btn_clear = 1'b0;
        check("rst_clr.pre", 32'(bus.clear), 32'd1);
        reset = 1'b0; tick();
        check("rst_clr.clear", 32'(bus.clear),   32'd0);
        check("rst_clr.state", 32'(bus.state_o), 32'd0);
        reset = 1'b1; tick(); tick();
        check("rst_clr.stay", 32'(bus.state_o), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/stopwatch_ctrl_fsm.md
STOPWATCH_CTRL_FSM -- requirements
Module: stopwatch_ctrl_fsm

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- NUM_MODES, 2, number of run modes (2..8).
- MD_W, 1, run_md width; SHALL satisfy 2**MD_W >= NUM_MODES.
- CLEAR_CYCLES, 1, clear pulse length in cycles (1..255).
- LAP_W, 4, lap counter width (1..8).
- CMD_RUN / CMD_STOP / CMD_CLEAR / CMD_MODE / CMD_LAP, "r" / "s" / "c" / "m" / "l", UART command bytes.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, sole clock, rising edge.
- reset, in, 1, synchronous active-low reset.
- btn_run_stop, in, 1, single-cycle run/stop pulse.
- btn_clear, in, 1, single-cycle clear pulse.
- btn_mode, in, 1, single-cycle mode-advance pulse.
- btn_lap, in, 1, single-cycle lap pulse.
- rx_data, in, 8, UART received byte.
- rx_done, in, 1, rx_data valid this cycle.
- enable, out, 1, counter run enable.
- clear, out, 1, counter clear.
- rd_en, out, 1, UART FIFO read strobe.
- run_md, out, MD_W, active run mode.
- lap_hold, out, 1, display freeze while counting continues.
- lap_cnt, out, LAP_W, laps taken since last clear.
- state_o, out, 2, current state encoding.

Function
REQ-003 The FSM SHALL have exactly four states: STOP=0, RUN=1, LAP=2, CLEAR=3; state_o SHALL equal the current state.
REQ-004 On a cycle with rx_done=1, the block SHALL register rx_data into a command register and assert rd_en for exactly the following cycle.
REQ-005 The command register SHALL hold its byte for one cycle only, then return to 0x00.
REQ-006 A UART command SHALL change state two cycles after its rx_done; a button SHALL change state one cycle after its pulse.
REQ-007 Each event SHALL be the OR of its button and its UART command; unrecognised bytes SHALL be ignored, but rd_en SHALL still pulse for them.
REQ-008 Event priority within a cycle SHALL be run_stop > clear > mode > lap; exactly one event SHALL act per cycle, and lower-priority events that cycle SHALL be discarded.
REQ-009 STOP transitions:
- run_stop -> RUN.
- clear -> CLEAR.
- mode and lap SHALL be ignored.
REQ-010 RUN transitions:
- run_stop -> STOP.
- lap -> LAP, and lap_cnt SHALL increment.
- mode SHALL advance run_md and stay in RUN.
- clear SHALL be ignored.
REQ-011 LAP transitions:
- run_stop -> STOP.
- lap -> RUN, and lap_cnt SHALL be unchanged.
- mode SHALL advance run_md and stay in LAP.
- clear SHALL be ignored.
REQ-012 run_md SHALL advance by 1 and wrap from NUM_MODES-1 to 0.
REQ-013 run_md SHALL be retained across STOP, so that a restart resumes in the last mode.
REQ-014 lap_cnt SHALL saturate at 2**LAP_W-1; further laps SHALL still enter LAP and toggle lap_hold.
REQ-015 CLEAR SHALL last exactly CLEAR_CYCLES cycles via an internal counter, then go to STOP.
REQ-016 While in CLEAR, all events SHALL be ignored; commands arriving during CLEAR SHALL be consumed (rd_en pulses) and discarded.
REQ-017 On entry to CLEAR, run_md SHALL reset to 0 and lap_cnt SHALL reset to 0.
REQ-018 Outputs SHALL be Moore, decoded from the state register:
- enable=1 in RUN and LAP.
- clear=1 in CLEAR only.
- lap_hold=1 in LAP only.
REQ-019 A transition from LAP to STOP SHALL deassert lap_hold on the same cycle the state changes.

Reset
REQ-020 With reset=0 sampled at a rising clk edge, the next-cycle values SHALL be:
- state = STOP, so state_o = 0.
- enable = 0, clear = 0, rd_en = 0, lap_hold = 0.
- run_md = 0, lap_cnt = 0.
- command register = 0x00, CLEAR counter = 0.
REQ-021 Reset asserted mid-CLEAR or mid-LAP SHALL abort the state immediately, and a pending command byte SHALL be dropped.

Verification
REQ-022 Button path: btn_run_stop pulse in STOP -> enable=1, state_o=1 next cycle; a second pulse -> enable=0, state_o=0.
REQ-023 UART path: rx_done with rx_data="r" at cycle N -> rd_en=1 at N+1, enable=1 at N+2; rx_data=0x41 -> rd_en pulse only, no state change.
REQ-024 Mode wrap: NUM_MODES=3, in RUN apply 4 btn_mode pulses -> run_md sequence 1,2,0,1. Then stop and restart -> run_md=1.
REQ-025 Lap saturation: LAP_W=2, 5 lap entries -> lap_cnt saturates at 3, with lap_hold toggling each lap event. Then run_stop in LAP -> lap_hold=0, enable=0.
REQ-026 Clear: CLEAR_CYCLES=4, btn_clear in STOP -> clear=1 for exactly 4 cycles, then STOP with run_md=0 and lap_cnt=0. A "r" command received during CLEAR -> ignored.
REQ-027 Priority and reset: btn_run_stop together with UART "c" in STOP -> RUN. reset=0 during LAP -> all outputs at reset values next cycle.
